// File: rtl/wb_frame_src.sv
// Frame source: plays back frames of symbols from a small pattern memory or a
// counter pattern over a Wishbone-style write handshake, with inter-frame gaps.
module wb_frame_src #(
  parameter int unsigned DW = 2,
  parameter int unsigned AW = 12,
  parameter int unsigned CW = 16
) (
  input  logic          CLK_I,
  input  logic          RST_I,
  input  logic          LD_WE,
  input  logic [AW-1:0] LD_ADDR,
  input  logic [DW-1:0] LD_DAT,
  input  logic          START,
  input  logic          ABORT,
  input  logic          CFG_MODE,
  input  logic [CW-1:0] CFG_LEN,
  input  logic [CW-1:0] CFG_NFRM,
  input  logic [CW-1:0] CFG_GAP,
  output logic [DW-1:0] DAT_O,
  output logic          WE_O,
  output logic          STB_O,
  output logic          CYC_O,
  input  logic          ACK_I,
  output logic          BUSY,
  output logic          DONE,
  output logic [CW-1:0] FRM_CNT
);

  localparam int unsigned DEPTH = 2 ** AW;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PREP = 2'd1;
  localparam logic [1:0] S_XFER = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;

  logic [DW-1:0] mem [DEPTH];

  logic [1:0]    state_q, state_d;
  logic          mode_q, mode_d;
  logic [CW-1:0] len_q, len_d;
  logic [CW-1:0] nfrm_q, nfrm_d;
  logic [CW-1:0] gap_q, gap_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] k_q, k_d;
  logic [CW-1:0] gcnt_q, gcnt_d;
  logic [CW-1:0] frm_q, frm_d;
  logic [DW-1:0] dat_q, dat_d;
  logic          act_q, act_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [CW-1:0] k_next_c;
  logic [DW-1:0] sym_c;
  logic [CW-1:0] frm_inc_c;

  // Symbol index of the next fetch: restarts at 0 on every frame entry.
  assign k_next_c  = (state_q == S_XFER) ? k_q + CW'(1) : '0;
  assign sym_c     = mode_q ? DW'(k_next_c) : mem[ptr_q];
  assign frm_inc_c = frm_q + CW'(1);

  // Pattern memory: loadable only while idle, never cleared by reset.
  always_ff @(posedge CLK_I) begin
    if (LD_WE && (state_q == S_IDLE)) mem[LD_ADDR] <= LD_DAT;
  end

  always_ff @(posedge CLK_I) begin
    if (!RST_I) begin
      state_q <= S_IDLE;
      mode_q  <= 1'b0;
      len_q   <= '0;
      nfrm_q  <= '0;
      gap_q   <= '0;
      ptr_q   <= '0;
      k_q     <= '0;
      gcnt_q  <= '0;
      frm_q   <= '0;
      dat_q   <= '0;
      act_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      len_q   <= len_d;
      nfrm_q  <= nfrm_d;
      gap_q   <= gap_d;
      ptr_q   <= ptr_d;
      k_q     <= k_d;
      gcnt_q  <= gcnt_d;
      frm_q   <= frm_d;
      dat_q   <= dat_d;
      act_q   <= act_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    len_d   = len_q;
    nfrm_d  = nfrm_q;
    gap_d   = gap_q;
    ptr_d   = ptr_q;
    k_d     = k_q;
    gcnt_d  = gcnt_q;
    frm_d   = frm_q;
    dat_d   = dat_q;
    act_d   = act_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (START && (CFG_LEN != '0) && (CFG_NFRM != '0)) begin
          mode_d  = CFG_MODE;
          len_d   = CFG_LEN;
          nfrm_d  = CFG_NFRM;
          gap_d   = CFG_GAP;
          ptr_d   = '0;
          frm_d   = '0;
          busy_d  = 1'b1;
          state_d = S_PREP;
        end
      end
      S_PREP: begin
        dat_d   = sym_c;
        ptr_d   = ptr_q + AW'(1);
        k_d     = '0;
        act_d   = 1'b1;
        state_d = S_XFER;
      end
      S_XFER: begin
        if (ACK_I) begin
          if (k_q == len_q - CW'(1)) begin
            frm_d = frm_inc_c;
            dat_d = '0;
            act_d = 1'b0;
            if (frm_inc_c == nfrm_q) begin
              busy_d  = 1'b0;
              done_d  = 1'b1;
              state_d = S_IDLE;
            end else begin
              gcnt_d  = (gap_q == '0) ? CW'(1) : gap_q;
              state_d = S_GAP;
            end
          end else begin
            dat_d = sym_c;
            ptr_d = ptr_q + AW'(1);
            k_d   = k_next_c;
          end
        end
      end
      default: begin
        // Gap: prefetch on the last idle cycle so XFER starts with valid data.
        if (gcnt_q == CW'(1)) begin
          dat_d   = sym_c;
          ptr_d   = ptr_q + AW'(1);
          k_d     = '0;
          act_d   = 1'b1;
          state_d = S_XFER;
        end else begin
          gcnt_d = gcnt_q - CW'(1);
        end
      end
    endcase

    if (ABORT && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      frm_d   = frm_q;
      dat_d   = '0;
      act_d   = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end
  end

  assign DAT_O   = dat_q;
  assign WE_O    = act_q;
  assign STB_O   = act_q;
  assign CYC_O   = act_q;
  assign BUSY    = busy_q;
  assign DONE    = done_q;
  assign FRM_CNT = frm_q;

endmodule

// File: tb/tb_wb_frame_src.sv
// Directed bench for wb_frame_src: expected symbols are queued per run and
// popped as the source presents them.
module tb_wb_frame_src;

  localparam int unsigned DW    = 2;
  localparam int unsigned AW    = 3;
  localparam int unsigned CW    = 16;
  localparam int unsigned DEPTH = 2 ** AW;

  logic          clk = 1'b0;
  logic          rst_n, ld_we, start, abort, cfg_mode, ack;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_dat;
  logic [CW-1:0] cfg_len, cfg_nfrm, cfg_gap;
  logic [DW-1:0] dat;
  logic          we, stb, cyc, busy, done;
  logic [CW-1:0] frm_cnt;

  logic [DW-1:0] mem_m [DEPTH];
  int            n_asserts = 0;
  int            n_fail = 0;

  wb_frame_src #(.DW(DW), .AW(AW), .CW(CW)) dut (
    .CLK_I(clk), .RST_I(rst_n), .LD_WE(ld_we), .LD_ADDR(ld_addr), .LD_DAT(ld_dat),
    .START(start), .ABORT(abort), .CFG_MODE(cfg_mode), .CFG_LEN(cfg_len),
    .CFG_NFRM(cfg_nfrm), .CFG_GAP(cfg_gap), .DAT_O(dat), .WE_O(we), .STB_O(stb),
    .CYC_O(cyc), .ACK_I(ack), .BUSY(busy), .DONE(done), .FRM_CNT(frm_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int i, input logic [DW-1:0] d);
    ld_we = 1'b1;
    ld_addr = AW'(i);
    ld_dat = d;
    tick();
    ld_we = 1'b0;
    mem_m[i] = d;
  endtask

  task automatic start_run(input logic mode, input int len, input int nfrm, input int gap);
    cfg_mode = mode;
    cfg_len = CW'(len);
    cfg_nfrm = CW'(nfrm);
    cfg_gap = CW'(gap);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Full run: queue expected symbols, then pop them as STB/ACK handshakes occur.
  task automatic run(input logic mode, input int len, input int nfrm, input int gap,
                     input bit ack_alt, input bit poke, input int exp_busy, input int exp_gap);
    logic [DW-1:0] q[$];
    int busy_n = 0;
    int gap_n = 0;
    int cyc_n = 0;
    bit ended = 0;
    for (int f = 0; f < nfrm; f++)
      for (int k = 0; k < len; k++)
        q.push_back(mode ? DW'(k) : mem_m[(f * len + k) % DEPTH]);
    start_run(mode, len, nfrm, gap);
    check("prep_busy", 32'(busy), 1);
    check("prep_stb", 32'(stb), 0);
    tick();
    check("first_stb", 32'(stb), 1);
    while (!ended && cyc_n < 400) begin
      start = 1'b0;
      ld_we = 1'b0;
      if (!busy) begin
        ended = 1;
        check("done_at_end", 32'(done), 1);
        check("frm_cnt_end", 32'(frm_cnt), 32'(nfrm));
        check("cyc_end", 32'(cyc), 0);
      end else begin
        busy_n++;
        check("done_while_busy", 32'(done), 0);
        if (stb) begin
          check("cyc_we", 32'({cyc, we}), 32'h3);
          check("sym_avail", 32'(q.size() != 0), 1);
          if (q.size() != 0) check("sym", 32'(dat), 32'(q[0]));
          ack = ack_alt ? cyc_n[0] : 1'b1;
          if (ack && q.size() != 0) void'(q.pop_front());
        end else begin
          check("gap_dat", 32'(dat), 0);
          check("gap_cyc", 32'({cyc, we}), 0);
          gap_n++;
          ack = 1'b1;
        end
        if (poke && cyc_n == 1) begin
          start = 1'b1;
          cfg_mode = ~mode;
          cfg_len = CW'(1);
          cfg_nfrm = CW'(1);
          ld_we = 1'b1;
          ld_addr = '0;
          ld_dat = ~mem_m[0];
        end
        cyc_n++;
        tick();
      end
    end
    check("run_ended", 32'(ended), 1);
    check("queue_empty", 32'(q.size()), 0);
    if (exp_busy >= 0) check("busy_cycles", 32'(busy_n), 32'(exp_busy));
    check("gap_cycles", 32'(gap_n), 32'(exp_gap));
    ack = 1'b0;
    tick();
    check("done_one_cycle", 32'(done), 0);
  endtask

  initial begin
    rst_n = 1'b0; ld_we = 1'b0; start = 1'b0; abort = 1'b0; cfg_mode = 1'b0; ack = 1'b0;
    ld_addr = '0; ld_dat = '0; cfg_len = '0; cfg_nfrm = '0; cfg_gap = '0;
    tick();
    tick();
    check("rst_outs", 32'({dat, we, stb, cyc, busy, done}), 0);
    check("rst_frm", 32'(frm_cnt), 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) load(i, DW'(i % 4));
    // Basic playback, two frames, gap of 3.
    run(1'b0, 4, 2, 3, 1'b0, 1'b0, 11, 3);
    // Same with stalls every other cycle.
    run(1'b0, 4, 2, 3, 1'b1, 1'b0, -1, 3);
    // Counter mode wraps modulo 2^DW.
    run(1'b1, 6, 1, 0, 1'b0, 1'b0, 6, 0);

    for (int i = 0; i < 8; i++) load(i, DW'(3 - (i % 3)));
    // Pointer runs across frames and wraps the memory; zero gap means one idle cycle.
    run(1'b0, 5, 2, 0, 1'b0, 1'b0, 11, 1);
    // START and LD_WE while busy are ignored.
    run(1'b0, 4, 1, 0, 1'b1, 1'b1, -1, 0);

    // Abort after two accepted symbols.
    start_run(1'b0, 4, 2, 1);
    tick();
    ack = 1'b1;
    check("abort_s0", 32'(dat), 32'(mem_m[0]));
    tick();
    check("abort_s1", 32'(dat), 32'(mem_m[1]));
    tick();
    check("abort_s2", 32'(dat), 32'(mem_m[2]));
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    ack = 1'b0;
    check("abort_outs", 32'({dat, we, stb, cyc, busy, done}), 0);
    check("abort_frm", 32'(frm_cnt), 0);
    tick();
    check("abort_no_done", 32'({busy, done}), 0);
    run(1'b0, 3, 2, 2, 1'b0, 1'b0, 8, 2);

    // Zero-length and zero-frame starts are ignored.
    start_run(1'b0, 0, 2, 1);
    check("len0_busy", 32'(busy), 0);
    tick();
    check("len0_idle", 32'({busy, done, stb}), 0);
    start_run(1'b1, 3, 0, 1);
    check("nfrm0_busy", 32'(busy), 0);

    // Reset mid-frame.
    start_run(1'b0, 4, 2, 1);
    tick();
    ack = 1'b1;
    tick();
    check("pre_rst_stb", 32'(stb), 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    ack = 1'b0;
    check("rst_mid_outs", 32'({dat, we, stb, cyc, busy, done}), 0);
    check("rst_mid_frm", 32'(frm_cnt), 0);
    tick();
    check("rst_no_done", 32'(done), 0);
    // Memory survives reset.
    run(1'b0, 8, 1, 0, 1'b0, 1'b0, 8, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
